// File: rtl/fft_seq_ctrl_if.sv
// rtl/fft_seq_ctrl_if.sv - handshake/strobe bundle between the FFT sequencer and its datapath
//
// Purpose : groups every non-clock/reset signal of fft_seq_ctrl.
// Modports: master - the sequencer (drives all *_o, samples all *_i)
//           slave  - the surrounding datapath / frame source / consumer
// Signals : start_i, busy_o, done_o               frame control
//           in_valid_i, in_ready_o                sample input handshake
//           wr_en_o, wr_addr_o                    bit-reversed load writes
//           bf_valid_o, addr_a_o, addr_b_o,
//           twiddle_addr_o, memsel_o, stage_o     butterfly read issue
//           wb_en_o, wb_addr_a_o, wb_addr_b_o,
//           wb_sel_o                              delayed write-back
//           rd_en_o, rd_addr_o, out_valid_o,
//           out_ready_i, out_last_o               result streaming
interface fft_seq_ctrl_if #(
    parameter int LOG2N = 10
) ();
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             wr_en_o;
    logic [LOG2N-1:0] wr_addr_o;
    logic             bf_valid_o;
    logic [LOG2N-1:0] addr_a_o;
    logic [LOG2N-1:0] addr_b_o;
    logic [LOG2N-2:0] twiddle_addr_o;
    logic             memsel_o;
    logic [3:0]       stage_o;
    logic             wb_en_o;
    logic [LOG2N-1:0] wb_addr_a_o;
    logic [LOG2N-1:0] wb_addr_b_o;
    logic             wb_sel_o;
    logic             rd_en_o;
    logic [LOG2N-1:0] rd_addr_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;

    modport master (
        input  start_i, in_valid_i, out_ready_i,
        output busy_o, done_o, in_ready_o, wr_en_o, wr_addr_o,
               bf_valid_o, addr_a_o, addr_b_o, twiddle_addr_o, memsel_o, stage_o,
               wb_en_o, wb_addr_a_o, wb_addr_b_o, wb_sel_o,
               rd_en_o, rd_addr_o, out_valid_o, out_last_o
    );

    modport slave (
        output start_i, in_valid_i, out_ready_i,
        input  busy_o, done_o, in_ready_o, wr_en_o, wr_addr_o,
               bf_valid_o, addr_a_o, addr_b_o, twiddle_addr_o, memsel_o, stage_o,
               wb_en_o, wb_addr_a_o, wb_addr_b_o, wb_sel_o,
               rd_en_o, rd_addr_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - load/compute/unload sequencer for an in-place radix-2 FFT
//
// Purpose : loads one frame bit-reversed into bank 0, issues every butterfly of
//           all LOG2N stages (ping-pong banks, one butterfly per cycle), delays
//           the operand addresses into write-back strobes, then streams the N
//           result bins out through a valid/ready handshake.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - fft_seq_ctrl_if.master, all strobes and handshakes
module fft_seq_ctrl #(
    parameter int LOG2N    = 10,
    parameter int BFLY_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    fft_seq_ctrl_if.master bus
);
    localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

    localparam logic [LOG2N:0]   CNT_ONE    = (LOG2N+1)'(1);
    localparam logic [LOG2N:0]   CNT_N      = CNT_ONE << LOG2N;
    localparam logic [LOG2N:0]   CNT_LAST   = CNT_N - CNT_ONE;
    localparam logic [LOG2N-2:0] J_ONE      = (LOG2N-1)'(1);
    localparam logic [LOG2N-2:0] J_LAST     = '1;
    localparam logic [LOG2N-1:0] A_ONE      = LOG2N'(1);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(BFLY_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N:0]   cnt_q, cnt_d;
    logic [3:0]       stage_q, stage_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic             in_ready, wr_en, bf_valid, rd_en;
    logic [LOG2N-1:0] wr_addr, rd_addr;

    // write-back pipe: {valid, addr_a, addr_b, bank}
    logic [BFLY_LAT-1:0] wb_v_q;
    logic [BFLY_LAT-1:0] wb_s_q;
    logic [LOG2N-1:0]    wb_a_q [BFLY_LAT];
    logic [LOG2N-1:0]    wb_b_q [BFLY_LAT];

    logic [LOG2N-1:0] j_ext, half, pos, grp_sh, addr_a, addr_b;
    logic [LOG2N-2:0] tw;
    logic             in_stage;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            j_q         <= j_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        j_d         = j_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        bf_valid    = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                    j_d     = '0;
                    drain_d = '0;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    wr_en   = 1'b1;
                    wr_addr = bitrev(cnt_q[LOG2N-1:0]);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        j_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_COMPUTE: begin
                bf_valid = 1'b1;
                if (j_q == J_LAST) begin
                    j_d     = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    j_d = j_q + J_ONE;
                end
            end

            // Idle long enough for the last write-back of this stage to land
            // before the next stage reads the bank it wrote.
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_UNLOAD;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        state_d = S_COMPUTE;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_ONE;
                end
            end

            S_UNLOAD: begin
                rd_addr = cnt_q[LOG2N-1:0];
                // Read only when the output register is empty or being drained,
                // so the RAM output never changes under a stalled bin.
                rd_en   = (cnt_q < CNT_N) && (!out_valid_q || bus.out_ready_i);
                if (rd_en) begin
                    cnt_d       = cnt_q + CNT_ONE;
                    out_valid_d = 1'b1;
                    last_d      = (cnt_q == CNT_LAST);
                end else if (out_valid_q && bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                end
                if (out_valid_q && bus.out_ready_i && last_q) begin
                    out_valid_d = 1'b0;
                    last_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Butterfly addressing: addr_a is j with a zero inserted at bit 'stage',
    // addr_b sets that bit; the twiddle index scales pos up to the N/2 ROM.
    always_comb begin
        j_ext  = {1'b0, j_q};
        half   = A_ONE << stage_q;
        pos    = j_ext & (half - A_ONE);
        grp_sh = (j_ext >> stage_q) << (stage_q + 4'd1);
        addr_a = grp_sh | pos;
        addr_b = addr_a + half;
        tw     = pos[LOG2N-2:0] << (STAGE_LAST - stage_q);
    end

    assign in_stage = (state_q == S_COMPUTE) || (state_q == S_DRAIN);

    // Non-valid slots carry zeros so the write-back outputs stay quiet when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_v_q <= '0;
            wb_s_q <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                wb_a_q[i] <= '0;
                wb_b_q[i] <= '0;
            end
        end else begin
            wb_v_q[0] <= bf_valid;
            wb_s_q[0] <= bf_valid & ~stage_q[0];
            wb_a_q[0] <= bf_valid ? addr_a : '0;
            wb_b_q[0] <= bf_valid ? addr_b : '0;
            for (int i = 1; i < BFLY_LAT; i++) begin
                wb_v_q[i] <= wb_v_q[i-1];
                wb_s_q[i] <= wb_s_q[i-1];
                wb_a_q[i] <= wb_a_q[i-1];
                wb_b_q[i] <= wb_b_q[i-1];
            end
        end
    end

    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.done_o         = done_q;
    assign bus.in_ready_o     = in_ready;
    assign bus.wr_en_o        = wr_en;
    assign bus.wr_addr_o      = wr_addr;
    assign bus.bf_valid_o     = bf_valid;
    assign bus.addr_a_o       = bf_valid ? addr_a : '0;
    assign bus.addr_b_o       = bf_valid ? addr_b : '0;
    assign bus.twiddle_addr_o = bf_valid ? tw : '0;
    assign bus.memsel_o       = in_stage & stage_q[0];
    assign bus.stage_o        = in_stage ? stage_q : 4'd0;
    assign bus.wb_en_o        = wb_v_q[BFLY_LAT-1];
    assign bus.wb_addr_a_o    = wb_a_q[BFLY_LAT-1];
    assign bus.wb_addr_b_o    = wb_b_q[BFLY_LAT-1];
    assign bus.wb_sel_o       = wb_s_q[BFLY_LAT-1];
    assign bus.rd_en_o        = rd_en;
    assign bus.rd_addr_o      = rd_addr;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_last_o     = out_valid_q & last_q;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - scoreboard bench for fft_seq_ctrl
module tb_fft_seq_ctrl;
    localparam int LOG2N    = 10;
    localparam int BFLY_LAT = 4;
    localparam int N        = 1 << LOG2N;
    localparam int HALF_N   = N / 2;

    typedef struct packed { int a; int b; int tw; int ms; int st; } bf_t;
    typedef struct packed { int cyc; int a; int b; int sel; } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_seq_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(BFLY_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   wr_q[$];
    int   bin_q[$];
    bf_t  bf_q[$];
    wb_t  wb_q[$];
    logic [15:0] ram_q;

    function automatic logic [15:0] ram_data(input int idx);
        return 16'((idx * 37 + 181) % 65536);
    endfunction

    // result RAM: one-cycle read latency, output holds while rd_en_o is low
    always @(posedge clk) begin
        if (bus.rd_en_o) ram_q <= ram_data(int'(bus.rd_addr_o));
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev_m(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    function automatic bf_t bf_model(input int s, input int j);
        bf_t m;
        int  h, pos, grp;
        h    = 1 << s;
        pos  = j % h;
        grp  = j / h;
        m.a  = grp * 2 * h + pos;
        m.b  = m.a + h;
        m.tw = pos * (HALF_N / h);
        m.ms = s % 2;
        m.st = s;
        return m;
    endfunction

    function automatic int any_out();
        return int'(|{bus.busy_o, bus.done_o, bus.in_ready_o, bus.wr_en_o, bus.wr_addr_o,
                      bus.bf_valid_o, bus.addr_a_o, bus.addr_b_o, bus.twiddle_addr_o,
                      bus.memsel_o, bus.stage_o, bus.wb_en_o, bus.wb_addr_a_o,
                      bus.wb_addr_b_o, bus.wb_sel_o, bus.rd_en_o, bus.rd_addr_o,
                      bus.out_valid_o, bus.out_last_o});
    endfunction

    task automatic run_frame(input bit gap_in, input bit rnd_ready, input bit poke_start,
                             input bit abort);
        int  sent, bf_idx, gap, first_bf, last_hs, last_wb, first_rd, hs_cnt, last_bin_k, idx;
        bit  seen_bf, done_seen, aborted, ld, vin, do_abort;
        bf_t e;
        wb_t w;
        wr_q.delete(); bin_q.delete(); bf_q.delete(); wb_q.delete();
        for (int i = 0; i < N; i++) bin_q.push_back(i);
        for (int s = 0; s < LOG2N; s++)
            for (int j = 0; j < HALF_N; j++) bf_q.push_back(bf_model(s, j));
        sent = 0; bf_idx = 0; gap = 0; first_bf = 0; last_hs = 0; last_wb = 0;
        first_rd = -1; hs_cnt = 0; last_bin_k = 0;
        seen_bf = 0; done_seen = 0; aborted = 0;

        for (int k = 0; k < 20000 && !done_seen && !aborted; k++) begin
            @(posedge clk); #1;
            do_abort = 0;
            bus.start_i = (k == 0) || (poke_start && seen_bf && k == first_bf + 700);
            ld  = (k >= 1) && (sent < N);
            vin = ld && (!gap_in || (k % 3) == 0);
            bus.in_valid_i = vin;
            if (vin) begin
                wr_q.push_back(bitrev_m(sent));
                sent++;
            end
            bus.out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);

            if (ld) begin
                check("in_ready", int'(bus.in_ready_o), 1);
                check("wr_en", int'(bus.wr_en_o), int'(vin));
                if (vin) begin
                    idx = wr_q.pop_front();
                    check("wr_addr", int'(bus.wr_addr_o), idx);
                    if (sent == N) last_hs = k;
                end
            end
            if (k >= 1 && !bus.done_o) check("busy", int'(bus.busy_o), 1);

            if (bus.bf_valid_o) begin
                if (!seen_bf) begin
                    check("compute_start", k, last_hs + 1);
                    first_bf = k;
                    seen_bf  = 1;
                end else if (gap > 0) begin
                    check("stage_gap", gap, BFLY_LAT);
                end
                gap = 0;
                if (bf_q.size() == 0) begin
                    check("bf_count", bf_idx + 1, HALF_N * LOG2N);
                end else begin
                    e = bf_q.pop_front();
                    check("addr_a", int'(bus.addr_a_o), e.a);
                    check("addr_b", int'(bus.addr_b_o), e.b);
                    check("twiddle", int'(bus.twiddle_addr_o), e.tw);
                    check("memsel", int'(bus.memsel_o), e.ms);
                    check("stage", int'(bus.stage_o), e.st);
                    w.cyc = k + BFLY_LAT; w.a = e.a; w.b = e.b; w.sel = 1 - e.ms;
                    wb_q.push_back(w);
                    if (bf_idx == HALF_N + 1) begin
                        check("s1j1_a", int'(bus.addr_a_o), 1);
                        check("s1j1_b", int'(bus.addr_b_o), 3);
                        check("s1j1_tw", int'(bus.twiddle_addr_o), 256);
                    end
                    if (bf_idx == 9 * HALF_N + 5) begin
                        check("s9j5_a", int'(bus.addr_a_o), 5);
                        check("s9j5_b", int'(bus.addr_b_o), 517);
                        check("s9j5_tw", int'(bus.twiddle_addr_o), 5);
                    end
                    if (abort && bf_idx == 4 * HALF_N + 100) do_abort = 1;
                end
                bf_idx++;
            end else if (seen_bf) begin
                gap++;
            end

            if (bus.wb_en_o) begin
                if (wb_q.size() == 0) begin
                    check("wb_count", bf_idx + 1, bf_idx);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_cycle", k, w.cyc);
                    check("wb_addr_a", int'(bus.wb_addr_a_o), w.a);
                    check("wb_addr_b", int'(bus.wb_addr_b_o), w.b);
                    check("wb_sel", int'(bus.wb_sel_o), w.sel);
                end
                last_wb = k;
            end

            if (bus.rd_en_o && first_rd < 0) begin
                first_rd = k;
                check("unload_start", k, last_wb + 1);
            end

            if (bus.out_valid_o && bus.out_ready_i) begin
                if (bin_q.size() == 0) begin
                    check("bin_count", hs_cnt + 1, N);
                end else begin
                    idx = bin_q.pop_front();
                    check("bin_data", int'(ram_q), int'(ram_data(idx)));
                    check("bin_last", int'(bus.out_last_o), int'(idx == N - 1));
                end
                hs_cnt++;
                last_bin_k = k;
            end

            if (bus.done_o) begin
                check("done_bins", hs_cnt, N);
                check("done_latency", k, last_bin_k + 1);
                check("done_busy", int'(bus.busy_o), 0);
                done_seen = 1;
            end

            if (do_abort) begin
                bus.start_i = 1'b0; bus.in_valid_i = 1'b0;
                #1 rst = 1'b1;
                #1 check("async_reset", any_out(), 0);
                repeat (3) begin
                    @(negedge clk);
                    check("reset_hold", any_out(), 0);
                end
                @(posedge clk); #1 rst = 1'b0;
                repeat (BFLY_LAT + 2) begin
                    @(negedge clk);
                    check("post_reset_idle", any_out(), 0);
                end
                aborted = 1;
            end
        end

        if (abort) begin
            check("abort_reached", int'(aborted), 1);
        end else begin
            check("frame_done", int'(done_seen), 1);
            check("compute_cycles", last_wb - first_bf + 1, LOG2N * (HALF_N + BFLY_LAT));
            check("bf_left", bf_q.size(), 0);
            check("wb_left", wb_q.size(), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_pulse_width", int'(bus.done_o), 0);
            check("idle_after_done", any_out(), 0);
        end
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", any_out(), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", any_out(), 0);

        // full-rate load, random consumer stalls, stray start during compute
        run_frame(1'b0, 1'b1, 1'b1, 1'b0);
        // gapped load, reset in stage 4 at j=100
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        // clean frame after reset: gapped load, random stalls
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
